// File: rtl/regfile_mp.sv
// Register file with two registered read ports, one write port, and per-register "written" flags.
// Define REGFILE_BYPASS_EN for write-first collisions; leave it undefined for read-first.
module regfile_mp #(
    parameter int N = 16,
    parameter int A = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [A-1:0]      writenum,
    input  logic [N-1:0]      data_in,
    input  logic              read_a,
    input  logic [A-1:0]      readnum_a,
    input  logic              read_b,
    input  logic [A-1:0]      readnum_b,
    output logic [N-1:0]      data_out_a,
    output logic [N-1:0]      data_out_b,
    output logic [(2**A)-1:0] written
);
    localparam int D = 2 ** A;

    logic [N-1:0] regs_q [D];
    logic [N-1:0] data_out_a_q, data_out_a_d;
    logic [N-1:0] data_out_b_q, data_out_b_d;
    logic [D-1:0] written_q, written_d;
    logic [D-1:0] we_d;

    always_comb begin
        we_d = '0;
        we_d[writenum] = write;
        written_d = written_q | we_d;
    end

    // Read mux per port; a same-edge write to the read address is forwarded only in bypass builds.
    always_comb begin
        data_out_a_d = regs_q[readnum_a];
        data_out_b_d = regs_q[readnum_b];
`ifdef REGFILE_BYPASS_EN
        if (write && (writenum == readnum_a)) data_out_a_d = data_in;
        if (write && (writenum == readnum_b)) data_out_b_d = data_in;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < D; i++) regs_q[i] <= '0;
            data_out_a_q <= '0;
            data_out_b_q <= '0;
            written_q    <= '0;
        end else begin
            for (int i = 0; i < D; i++) begin
                if (we_d[i]) regs_q[i] <= data_in;
            end
            if (read_a) data_out_a_q <= data_out_a_d;
            if (read_b) data_out_b_q <= data_out_b_d;
            written_q <= written_d;
        end
    end

    assign data_out_a = data_out_a_q;
    assign data_out_b = data_out_b_q;
    assign written    = written_q;
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter N, default 16, data width in bits (1..64).
REQ-002 SHALL have parameter A, default 3, address width; depth D = 2^A registers (A = 1..6).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port write  input  1  write enable.
REQ-006 SHALL have port writenum  input  A  write address.
REQ-007 SHALL have port data_in  input  N  write data.
REQ-008 SHALL have port read_a  input  1  read enable, port A.
REQ-009 SHALL have port readnum_a  input  A  read address, port A.
REQ-010 SHALL have port read_b  input  1  read enable, port B.
REQ-011 SHALL have port readnum_b  input  A  read address, port B.
REQ-012 SHALL have port data_out_a  output  N  registered read data, port A.
REQ-013 SHALL have port data_out_b  output  N  registered read data, port B.
REQ-014 SHALL have port written  output  D  per-register "written since reset" flags, bit i for register i.

Function
REQ-015 SHALL hold D registers of N bits; register i updates to data_in on a rising edge where write=1 and writenum=i; all others hold.
REQ-016 SHALL set written[i] on the same edge register i is written; written bits clear only on reset.
REQ-017 SHALL update data_out_a on a rising edge where read_a=1 with the contents of register readnum_a; read latency exactly one cycle from address presentation.
REQ-018 SHALL hold data_out_a unchanged on edges where read_a=0; port B identical with read_b/readnum_b/data_out_b.
REQ-019 SHALL allow both read ports and the write port active in the same cycle, including both reads at the same address, each with an independent result.
REQ-020 SHALL, when a read and a write target the same address on the same edge, return per the REGFILE_BYPASS_EN rules (REQ-026/027); the register itself always takes data_in.
REQ-021 SHALL decode writenum to a one-hot D-bit write enable and select read data with a D-input N-bit mux per port; no X propagation for any in-range address (all A-bit values are in range).
REQ-022 SHALL contain no other state; no combinational path from any input to any output.

Reset
REQ-023 SHALL, while reset=1, force all D registers, data_out_a, data_out_b and written to 0 immediately, independent of clk.
REQ-024 SHALL ignore write, read_a and read_b on any edge where reset=1; an in-flight write coincident with reset assertion is lost.
REQ-025 SHALL resume normal operation on the first rising edge after reset deasserts; a read of an unwritten register returns 0.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined, a read whose address equals writenum with write=1 on the same edge SHALL load data_in into data_out (write-first).
REQ-027 Without REGFILE_BYPASS_EN, the same collision SHALL load the register's pre-edge value (read-first); all other behaviour identical.

Verification
REQ-028 Reset then read_a=1, readnum_a=5, read_b=1, readnum_b=0 -> next edge data_out_a=0, data_out_b=0, written=8'h00.
REQ-029 Write 16'hBEEF to R3, next cycle read_a at 3 -> data_out_a=16'hBEEF one edge after address; written=8'h08.
REQ-030 R2 holds 16'h1111; same edge write 16'h2222 to R2, read_a=1 at 2 -> data_out_a=16'h2222 with REGFILE_BYPASS_EN, 16'h1111 without; following read returns 16'h2222 in both builds.
REQ-031 Write R7=16'hA5A5, R1=16'h0F0F; read_a at 7, read_b at 1 same cycle -> data_out_a=16'hA5A5, data_out_b=16'h0F0F; then read_a=0, readnum_a=1 -> data_out_a stays 16'hA5A5.
REQ-032 Write all 8 registers with 16'h0100+i, assert reset mid-cycle between edges -> outputs, registers and written go to 0 before next edge; post-reset reads of all 8 return 0.
REQ-033 Parameter sweep N=32, A=5: write 32'hDEADBEEF to R31, read on both ports -> both return 32'hDEADBEEF; written=32'h8000_0000.
